// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared definitions for the baud tick generator:
//   - state_e     : run-control states (IDLE, RUN)
//   - CLK_HZ_DEF  : default system clock frequency (25 MHz)
//   - BAUD_DEF    : default bit rate (9600)
//   - calc_div()  : clocks per oversample tick, rounded to nearest
//   - scnt_width(): width of the oversample counter for a given ratio
// ---------------------------------------------------------------------------
package baud_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned CLK_HZ_DEF = 25_000_000;
  localparam int unsigned BAUD_DEF   = 9600;

  // Rounds clk_hz / (baud * os) to the nearest integer. A zero rate returns 0,
  // which the prescaler treats as a divisor of 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned rate;
    rate = baud * os;
    if (rate == 0) begin
      return 0;
    end
    return (clk_hz + rate / 2) / rate;
  endfunction

  // The oversample counter needs ceil(log2(os)) bits but never fewer than one.
  function automatic int unsigned scnt_width(input int unsigned os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/baud_prescaler.sv
// ---------------------------------------------------------------------------
// baud_prescaler
// Holds the runtime divisor and the clocks-per-os_tick prescaler.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   run_i     : generator is currently in RUN
//   clear_i   : force the prescaler to 0 on the next edge
//   load_i    : capture div_i into the divisor register
//   div_i     : new clocks-per-os_tick value
//   os_tick_o : one-cycle oversample tick
// ---------------------------------------------------------------------------
module baud_prescaler
  import baud_pkg::*;
#(
  parameter int unsigned           DIV_W   = 16,
  parameter logic [DIV_W-1:0]      DEF_DIV = DIV_W'(calc_div(CLK_HZ_DEF, BAUD_DEF, 16))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             os_tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic [DIV_W-1:0] last_cnt;

  // A stored divisor of 0 behaves as 1, so the terminal count is 0 in both
  // cases and the tick fires every cycle.
  always_comb begin
    last_cnt = '0;
    if (div_q != '0) begin
      last_cnt = div_q - DIV_W'(1);
    end
  end

  // Tick is decoded purely from registers so downstream logic sees no
  // combinational path from the control strobes.
  always_comb begin
    os_tick_o = run_i && (pcnt_q == last_cnt);
  end

  // The divisor is replaced whenever a load strobe arrives, in any state.
  always_comb begin
    div_d = div_q;
    if (load_i) begin
      div_d = div_i;
    end
  end

  // Counting restarts from 0 on clear so a reload or realign never produces
  // a truncated or stretched period; otherwise wrap on the terminal count.
  always_comb begin
    pcnt_d = pcnt_q + DIV_W'(1);
    if (clear_i || os_tick_o) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= DEF_DIV;
      pcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Oversampling and bit-rate tick source with a runtime-loadable divisor,
// free-running or counted-burst operation, and start/stop/realign control.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   div_i      : new clocks-per-os_tick value, captured on div_load
//   div_load   : one-cycle strobe loading div_i
//   limit_i    : baud_ticks per burst, 0 = free-run, captured on start
//   start      : one-cycle strobe starting or restarting (realigning) a run
//   stop       : one-cycle strobe aborting a run
//   os_tick    : one-cycle oversample tick
//   baud_tick  : one-cycle bit tick, coincident with an os_tick
//   busy       : high while in RUN
//   done       : one-cycle pulse after the final tick of a counted burst
//   baud_count : baud_ticks issued in the current run
// ---------------------------------------------------------------------------
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned BAUD    = BAUD_DEF,
  parameter int unsigned OS      = 16,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = calc_div(CLK_HZ, BAUD, OS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             start,
  input  logic             stop,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] baud_count
);

  localparam int unsigned       SCNT_W    = scnt_width(OS);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OS - 1);

  state_e state_q, state_d;

  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lim_q, lim_d;
  logic              done_q, done_d;

  logic run_q;
  logic restart;
  logic terminal;
  logic finish;
  logic presc_clear;

  // Stop has priority over start, so a simultaneous pair never (re)starts.
  always_comb begin
    run_q    = (state_q == RUN);
    restart  = start && !stop;
    terminal = (lim_q != '0) && ((cnt_q + CNT_W'(1)) == lim_q);
    finish   = run_q && !start && !stop && baud_tick && terminal;
  end

  // The prescaler and oversample counter sit at 0 whenever the next state is
  // IDLE, and restart from 0 on a realign or a divisor reload.
  always_comb begin
    presc_clear = (state_d != RUN) || restart || div_load;
  end

  baud_prescaler #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DIV_W'(DEF_DIV))
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .run_i     (run_q),
    .clear_i   (presc_clear),
    .load_i    (div_load),
    .div_i     (div_i),
    .os_tick_o (os_tick)
  );

  always_comb begin
    baud_tick = os_tick && (scnt_q == SCNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start realigns an active run and beats the terminal
  // count, so a start on the final tick restarts rather than completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (restart) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end else if (baud_tick && terminal) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy       = run_q;
    done       = done_q;
    baud_count = cnt_q;
  end

  // Oversample position within the current bit period.
  always_comb begin
    scnt_d = scnt_q;
    if (presc_clear) begin
      scnt_d = '0;
    end else if (os_tick) begin
      scnt_d = (scnt_q == SCNT_LAST) ? '0 : scnt_q + SCNT_W'(1);
    end
  end

  // The tick count survives the return to IDLE so the final value can be read
  // alongside done; it saturates rather than wrapping in free-run mode.
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (restart) begin
      cnt_d = '0;
      lim_d = limit_i;
    end else if (run_q && baud_tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    done_d = finish;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_q <= '0;
      cnt_q  <= '0;
      lim_q  <= '0;
      done_q <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_gen
// Drives the baud tick generator through reset, default rate, counted burst,
// realign, divisor change, collisions, async reset and a random sequence.
// Expected outputs come from an arithmetic model: a tick is due whenever the
// number of cycles since the last start/reload is a multiple of the period.
// Cycle numbers in the scenarios count the cycle carrying a strobe as 0.
// ---------------------------------------------------------------------------
module tb_baud_tick_gen;

  localparam int OS      = 16;
  localparam int DEF_DIV = 163;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div_i;
  logic        div_load;
  logic [15:0] limit_i;
  logic        start;
  logic        stop;
  logic        os_tick;
  logic        baud_tick;
  logic        busy;
  logic        done;
  logic [15:0] baud_count;

  logic [19:0] obs_vec;
  assign obs_vec = {os_tick, baud_tick, busy, done, baud_count};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  bit m_run;
  bit m_done;
  int m_org;
  int m_div;
  int m_cnt;
  int m_lim;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk        (clk),
    .reset      (reset),
    .div_i      (div_i),
    .div_load   (div_load),
    .limit_i    (limit_i),
    .start      (start),
    .stop       (stop),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick),
    .busy       (busy),
    .done       (done),
    .baud_count (baud_count)
  );

  function automatic int eff_div();
    return (m_div == 0) ? 1 : m_div;
  endfunction

  function automatic bit exp_os();
    return m_run && (((cyc - m_org + 1) % eff_div()) == 0);
  endfunction

  function automatic bit exp_baud();
    return m_run && (((cyc - m_org + 1) % (eff_div() * OS)) == 0);
  endfunction

  function automatic logic [19:0] exp_vec();
    return {exp_os(), exp_baud(), m_run, m_done, 16'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_org  = 0;
    m_div  = DEF_DIV;
    m_cnt  = 0;
    m_lim  = 0;
  endtask

  // Presents one cycle of strobes, advances one clock edge and updates the
  // model with the same decisions the edge is expected to make.
  task automatic applyStimulus(input bit st, input bit sp, input bit ld,
                               input int dv, input int lm);
    bit eb;
    bit term;
    eb       = exp_baud();
    term     = m_run && eb && (m_lim != 0) && ((m_cnt + 1) == m_lim);
    start    = st;
    stop     = sp;
    div_load = ld;
    div_i    = 16'(dv);
    limit_i  = 16'(lm);
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (m_run && eb && !(st && !sp) && (m_cnt != 65535)) m_cnt++;
    if (sp) begin
      m_run = 1'b0;
    end else if (st) begin
      m_run = 1'b1;
      m_org = cyc;
      m_cnt = 0;
      m_lim = lm;
    end else if (term) begin
      m_run  = 1'b0;
      m_done = 1'b1;
    end
    if (ld) begin
      m_div = dv;
      if (m_run) m_org = cyc;
    end
    @(negedge clk);
    start    = 1'b0;
    stop     = 1'b0;
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_hold got=%h want=%h", obs_vec, 20'h0);
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("[TB] FAIL reset_release got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_default_rate();
    int t0;
    int rel;
    int first_os;
    int first_baud;
    bit saw_done;
    first_os   = -1;
    first_baud = -1;
    saw_done   = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 2660; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL default_rate cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      if (os_tick && first_os < 0) first_os = rel;
      if (baud_tick && first_baud < 0) first_baud = rel;
      if (done) saw_done = 1'b1;
      applyStimulus(0, rel == 2650, 0, 0, 0);
    end
    checks++;
    if (first_os !== 163) begin
      failures++;
      $display("[TB] FAIL default_first_os got=%0d want=163", first_os);
    end
    checks++;
    if (first_baud !== 2608) begin
      failures++;
      $display("[TB] FAIL default_first_baud got=%0d want=2608", first_baud);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL default_no_done got=%0d want=0", saw_done);
    end
  endtask

  task automatic test_counted_burst();
    int t0;
    int rel;
    int bt[$];
    int done_at;
    int busy_low;
    int cnt_at_done;
    done_at     = -1;
    busy_low    = -1;
    cnt_at_done = -1;
    applyStimulus(0, 0, 1, 4, 0);
    applyStimulus(1, 0, 0, 0, 3);
    t0 = cyc;
    for (int i = 0; i < 210; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL burst cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      if (baud_tick) bt.push_back(rel);
      if (done && done_at < 0) begin
        done_at     = rel;
        cnt_at_done = int'(baud_count);
      end
      if (!busy && busy_low < 0) busy_low = rel;
      applyStimulus(0, 0, 0, 0, 0);
    end
    checks++;
    if (bt.size() != 3 || bt[0] != 64 || bt[1] != 128 || bt[2] != 192) begin
      failures++;
      $display("[TB] FAIL burst_ticks got=%0d ticks first=%0d want=3 ticks at 64,128,192",
               bt.size(), (bt.size() > 0) ? bt[0] : -1);
    end
    checks++;
    if (done_at !== 193) begin
      failures++;
      $display("[TB] FAIL burst_done got=%0d want=193", done_at);
    end
    checks++;
    if (busy_low !== 193) begin
      failures++;
      $display("[TB] FAIL burst_busy_low got=%0d want=193", busy_low);
    end
    checks++;
    if (cnt_at_done !== 3) begin
      failures++;
      $display("[TB] FAIL burst_count got=%0d want=3", cnt_at_done);
    end
  endtask

  task automatic test_realign();
    int t0;
    int rel;
    int first_after;
    int cnt_after;
    first_after = -1;
    cnt_after   = -1;
    applyStimulus(1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL realign cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      if (rel == 101) cnt_after = int'(baud_count);
      if (baud_tick && rel > 100 && first_after < 0) first_after = rel;
      applyStimulus(rel == 100, rel == 190, 0, 0, 0);
    end
    checks++;
    if (first_after !== 164) begin
      failures++;
      $display("[TB] FAIL realign_next_baud got=%0d want=164", first_after);
    end
    checks++;
    if (cnt_after !== 0) begin
      failures++;
      $display("[TB] FAIL realign_count got=%0d want=0", cnt_after);
    end
  endtask

  task automatic test_div_change();
    int t0;
    int rel;
    int osq[$];
    int fast_cnt;
    fast_cnt = 0;
    applyStimulus(1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 90; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL div_change cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      if (os_tick && rel > 30 && rel <= 60) osq.push_back(rel);
      if (os_tick && rel > 70 && rel <= 80) fast_cnt++;
      applyStimulus(0, rel == 85, (rel == 30) || (rel == 70), (rel == 30) ? 10 : 0, 0);
    end
    checks++;
    if (osq.size() != 3 || osq[0] != 40 || osq[1] != 50 || osq[2] != 60) begin
      failures++;
      $display("[TB] FAIL div_change_spacing got=%0d ticks first=%0d want=3 ticks at 40,50,60",
               osq.size(), (osq.size() > 0) ? osq[0] : -1);
    end
    checks++;
    if (fast_cnt !== 10) begin
      failures++;
      $display("[TB] FAIL div_zero_rate got=%0d want=10", fast_cnt);
    end
    applyStimulus(0, 0, 1, 4, 0);
  endtask

  task automatic test_collisions();
    int t0;
    int rel;
    int idle_bad;
    bit saw_done;
    int busy65;
    int busy101;
    idle_bad = 0;
    saw_done = 1'b0;
    busy65   = -1;
    busy101  = -1;
    applyStimulus(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL collide_idle got=%h want=%h", obs_vec, exp_vec());
      end
      if (busy || os_tick) idle_bad++;
      applyStimulus(0, 0, 0, 0, 0);
    end
    checks++;
    if (idle_bad !== 0) begin
      failures++;
      $display("[TB] FAIL collide_stop_start got=%0d active cycles want=0", idle_bad);
    end
    applyStimulus(1, 0, 0, 0, 1);
    t0 = cyc;
    for (int i = 0; i < 140; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL collide_run cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      if (done) saw_done = 1'b1;
      if (rel == 65) busy65 = int'(busy);
      if (rel == 101) busy101 = int'(busy);
      applyStimulus((rel == 64) || (rel == 100), rel == 100, 0, 0, 1);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL collide_no_done got=%0d want=0", saw_done);
    end
    checks++;
    if (busy65 !== 1 || busy101 !== 0) begin
      failures++;
      $display("[TB] FAIL collide_busy got=%0d/%0d want=1/0", busy65, busy101);
    end
  endtask

  task automatic test_async_reset();
    int t0;
    int rel;
    int first_os;
    first_os = -1;
    applyStimulus(1, 0, 0, 0, 5);
    t0 = cyc;
    for (int i = 0; i < 102; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL async_pre cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      applyStimulus(0, 0, 0, 0, 5);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec !== 20'h0) begin
      failures++;
      $display("[TB] FAIL async_reset_now got=%h want=%h", obs_vec, 20'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    t0 = cyc;
    for (int i = 0; i < 170; i++) begin
      rel = cyc - t0 + 1;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL async_post cycle=%0d got=%h want=%h", rel, obs_vec, exp_vec());
      end
      if (os_tick && first_os < 0) first_os = rel;
      applyStimulus(0, rel == 168, 0, 0, 0);
    end
    checks++;
    if (first_os !== DEF_DIV) begin
      failures++;
      $display("[TB] FAIL async_default_div got=%0d want=%0d", first_os, DEF_DIV);
    end
  endtask

  task automatic test_random();
    int r;
    bit st;
    bit sp;
    bit ld;
    for (int i = 0; i < 1500; i++) begin
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL random step=%0d got=%h want=%h", i, obs_vec, exp_vec());
      end
      r  = int'($urandom_range(0, 99));
      st = (r < 3) || (r == 5);
      sp = (r >= 3) && (r <= 5);
      ld = ($urandom_range(0, 99) < 2);
      applyStimulus(st, sp, ld, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    reset    = 1'b1;
    div_i    = '0;
    div_load = 1'b0;
    limit_i  = '0;
    start    = 1'b0;
    stop     = 1'b0;
    model_reset();
    test_reset();
    test_default_rate();
    test_counted_burst();
    test_realign();
    test_div_change();
    test_collisions();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
